// File: rtl/tone_i2s_synth_if.sv
// I2S audio DAC pins: master clock, frame clock, bit clock and serial data.
// The synthesiser drives them through the master modport; the DAC side uses slave.
interface tone_i2s_synth_if;
  logic audio_mclk;
  logic audio_lrck;
  logic audio_sck;
  logic audio_sdin;

  modport master (
    output audio_mclk,
    output audio_lrck,
    output audio_sck,
    output audio_sdin
  );

  modport slave (
    input audio_mclk,
    input audio_lrck,
    input audio_sck,
    input audio_sdin
  );
endinterface

// File: rtl/tone_i2s_synth.sv
// Two-channel square-wave tone synthesiser with volume scaling.
// The samples are serialised as 16-bit two's-complement I2S words.
module tone_i2s_synth #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned SIL_HZ = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              toneL,
  input  logic [31:0]              toneR,
  input  logic [2:0]               volume,
  input  logic                     mute,
  tone_i2s_synth_if.master         i2s
);

  logic [8:0]        cnt_q, cnt_next;
  logic              wrap;
  logic [3:0]        bit_idx;
  logic [1:0][31:0]  tone_in;
  logic [1:0][31:0]  tone_q;
  logic [1:0][31:0]  acc_q, acc_d;
  logic [1:0]        sq_q, sq_d;
  logic [1:0][32:0]  sum;
  logic [1:0]        silent;
  logic [1:0][15:0]  smp;
  logic [1:0][15:0]  frame_q, frame_d;
  logic [15:0]       amp;
  logic              sdin_q, sdin_d;

  assign tone_in[0] = toneL;
  assign tone_in[1] = toneR;

  assign cnt_next = cnt_q + 9'd1;
  assign wrap     = (cnt_q == 9'd511);
  assign bit_idx  = 4'd15 - cnt_next[7:4];

  always_comb begin
    amp = 16'h7000;
    case (volume)
      3'd0:    amp = 16'h0000;
      3'd1:    amp = 16'h1000;
      3'd2:    amp = 16'h2000;
      3'd3:    amp = 16'h4000;
      default: amp = 16'h7000;
    endcase
  end

  // Phase accumulator per channel; a changed tone restarts the phase, and
  // that restart takes priority over any overflow in the same cycle.
  always_comb begin
    silent = '0;
    sum    = '0;
    acc_d  = acc_q;
    sq_d   = sq_q;
    smp    = '0;
    for (int ch = 0; ch < 2; ch++) begin
      silent[ch] = (tone_q[ch] == 32'd0) || (tone_q[ch] >= SIL_HZ);
      sum[ch]    = {1'b0, acc_q[ch]} + {tone_q[ch], 1'b0};
      if ((tone_in[ch] != tone_q[ch]) || silent[ch]) begin
        acc_d[ch] = '0;
        sq_d[ch]  = 1'b0;
      end else if (sum[ch] >= 33'(CLK_HZ)) begin
        acc_d[ch] = 32'(sum[ch] - 33'(CLK_HZ));
        sq_d[ch]  = ~sq_q[ch];
      end else begin
        acc_d[ch] = sum[ch][31:0];
      end
      if (silent[ch] || mute) begin
        smp[ch] = 16'h0000;
      end else if (sq_q[ch]) begin
        smp[ch] = amp;
      end else begin
        smp[ch] = 16'h0000 - amp;
      end
    end
  end

  // The word shifted out at the wrap must be the freshly captured frame.
  always_comb begin
    frame_d = wrap ? smp : frame_q;
    sdin_d  = frame_d[cnt_next[8]][bit_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tone_q  <= '0;
      acc_q   <= '0;
      sq_q    <= '0;
      frame_q <= '0;
      sdin_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_next;
      tone_q  <= tone_in;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      frame_q <= frame_d;
      sdin_q  <= sdin_d;
    end
  end

  assign i2s.audio_mclk = cnt_q[1];
  assign i2s.audio_sck  = cnt_q[3];
  assign i2s.audio_lrck = cnt_q[8];
  assign i2s.audio_sdin = sdin_q;

endmodule

// File: tb/tb_tone_i2s_synth.sv
// Randomised bench for tone_i2s_synth: a closed-form tone/frame model predicts
// every I2S clock pin and every deserialised 16-bit word.
module tb_tone_i2s_synth;

  localparam longint CLK_HZ = 100_000_000;
  localparam int unsigned SIL_HZ = 50_000_000;

  logic        clk;
  logic        rst_n;
  logic [31:0] toneL, toneR;
  logic [2:0]  volume;
  logic        mute;

  tone_i2s_synth_if i2s ();

  tone_i2s_synth dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .toneL  (toneL),
    .toneR  (toneR),
    .volume (volume),
    .mute   (mute),
    .i2s    (i2s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [8:0]        mc;
  int unsigned       lat [2];
  longint            nacc [2];
  logic [15:0]       mfr [2];
  logic [15:0]       shreg;
  logic [15:0]       last_w [2];
  int                cyc;
  int                lrck_rise;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_silent(input int unsigned t);
    return (t == 0) || (t >= SIL_HZ);
  endfunction

  // Square level after n accumulation cycles: parity of completed half-periods.
  function automatic bit model_sq(input int ch);
    longint p;
    p = nacc[ch] * 2 * longint'(lat[ch]);
    return ((p / CLK_HZ) % 2) == 1;
  endfunction

  function automatic logic [15:0] model_sample(input int ch);
    logic [15:0] a;
    case (volume)
      3'd0:    a = 16'h0000;
      3'd1:    a = 16'h1000;
      3'd2:    a = 16'h2000;
      3'd3:    a = 16'h4000;
      default: a = 16'h7000;
    endcase
    if (mute || is_silent(lat[ch])) return 16'h0000;
    return model_sq(ch) ? a : 16'(17'h10000 - {1'b0, a});
  endfunction

  task automatic model_reset();
    mc = '0;
    shreg = '0;
    for (int ch = 0; ch < 2; ch++) begin
      lat[ch]  = 0;
      nacc[ch] = 0;
      mfr[ch]  = '0;
    end
  endtask

  task automatic step();
    int unsigned tin [2];
    @(posedge clk);
    if (mc == 9'd511) begin
      mfr[0] = model_sample(0);
      mfr[1] = model_sample(1);
    end
    tin[0] = toneL;
    tin[1] = toneR;
    for (int ch = 0; ch < 2; ch++) begin
      if (tin[ch] != lat[ch]) begin
        lat[ch]  = tin[ch];
        nacc[ch] = 0;
      end else if (is_silent(lat[ch])) begin
        nacc[ch] = 0;
      end else begin
        nacc[ch]++;
      end
    end
    mc = mc + 9'd1;
    cyc++;
    #1;
    check("clocks", {i2s.audio_mclk, i2s.audio_sck, i2s.audio_lrck}, {mc[1], mc[3], mc[8]});
    if (lrck_rise < 0 && i2s.audio_lrck === 1'b1) lrck_rise = cyc;
    if (mc[3:0] == 4'd8) shreg = {shreg[14:0], i2s.audio_sdin};
    if (mc[7:0] == 8'd248) begin
      last_w[mc[8]] = shreg;
      check(mc[8] ? "wordR" : "wordL", shreg, mfr[mc[8]]);
    end
  endtask

  task automatic run_to_cnt(input logic [8:0] target);
    for (int i = 0; i < 600 && mc != target; i++) step();
    if (mc != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sync: got %0d expected %0d", mc, target);
    end
  endtask

  function automatic logic [31:0] rand_tone();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return SIL_HZ;
      2:       return SIL_HZ - 1;
      3:       return $urandom_range(SIL_HZ, 32'hFFFF_FFFF);
      default: return $urandom_range(100_000, 20_000_000);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    toneL = 32'd0;
    toneR = 32'd0;
    volume = 3'd3;
    mute = 1'b0;
    cyc = 0;
    lrck_rise = -1;
    last_w[0] = '0;
    last_w[1] = '0;
    model_reset();

    // Reset hold and startup timing
    repeat (10) @(negedge clk);
    check("rst_pins", {i2s.audio_mclk, i2s.audio_lrck, i2s.audio_sck, i2s.audio_sdin}, 4'd0);
    toneL = 32'd1_000_000;
    toneR = SIL_HZ;
    rst_n = 1'b1;
    repeat (600) step();
    check("lrck_rise", lrck_rise, 256);

    // Randomised tones, volumes and mute
    for (int ph = 0; ph < 30; ph++) begin
      toneL  = rand_tone();
      toneR  = rand_tone();
      volume = 3'($urandom_range(0, 7));
      mute   = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(300, 1500)) step();
    end

    // Full volume with the left square held low for a whole frame
    mute = 1'b0;
    run_to_cnt(9'd0);
    toneL  = 32'd90_000;
    volume = 3'd7;
    repeat (760) step();
    check("vol7_low", last_w[0], 32'h9000);

    // Zero volume
    run_to_cnt(9'd0);
    toneL  = 32'd3_000_000;
    volume = 3'd0;
    repeat (760) step();
    check("vol0", last_w[0], 32'h0000);

    // Mute mid-frame: the following frame is all zeros
    volume = 3'd5;
    toneR  = SIL_HZ - 1;
    run_to_cnt(9'd100);
    mute = 1'b1;
    repeat (916) step();
    check("mute_L", last_w[0], 32'h0000);
    check("mute_R", last_w[1], 32'h0000);
    mute = 1'b0;
    repeat (1100) step();

    // Asynchronous reset during a right word
    run_to_cnt(9'd300);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {i2s.audio_mclk, i2s.audio_lrck, i2s.audio_sck, i2s.audio_sdin}, 4'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (504) step();
    check("post_rst_L", last_w[0], 32'h0000);
    check("post_rst_R", last_w[1], 32'h0000);
    repeat (1100) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_i2s_synth.md
Name: tone_i2s_synth

Overview:
- Downstream of the per-beat tone lookup stage. Consumes the left and right tone frequencies, given in Hz.
- Generates one square wave per channel with a phase accumulator, then scales it by a volume level.
- Serialises both channels as 16-bit two's-complement samples onto the board's I2S audio DAC interface (mclk, lrck, sck, sdin).

Parameters:
- CLK_HZ, 100_000_000: system clock frequency; also the accumulator modulus.
- SIL_HZ, 50_000_000: silence code. Any tone >= SIL_HZ, or tone == 0, is treated as silent.

Ports:
- clk  input  1: system clock, 100 MHz.
- rst_n  input  1: asynchronous active-low reset.
- toneL  input  32: left-channel frequency in Hz, or the silence code.
- toneR  input  32: right-channel frequency in Hz, or the silence code.
- volume  input  3: amplitude level, 0..7.
- mute  input  1: forces zero samples.
- audio_mclk  output  1: DAC master clock, clk/4.
- audio_lrck  output  1: frame clock, clk/512. 0 = left word, 1 = right word.
- audio_sck  output  1: serial bit clock, clk/16.
- audio_sdin  output  1: serial data, MSB first.

Behaviour:
- One clock domain, one async active-low reset.
- Reset clears all of the following to 0:
  - frame counter cnt[8:0]
  - accumulators and square bits
  - latched tones
  - frame registers
  - every output
- Clock outputs: cnt is a free-running 9-bit counter that wraps 511->0.
  - audio_mclk = cnt[1]
  - audio_sck = cnt[3]
  - audio_lrck = cnt[8]
  - All three are driven from registers. No combinational glitches are allowed.
- Tone latch (per channel): the tone is registered every cycle.
  - When the new input differs from the latched value, that channel's accumulator and square bit are cleared in the same cycle (phase reset).
- Accumulator (per channel): 32-bit acc with a 33-bit intermediate, s = acc + 2*tone.
  - If s >= CLK_HZ: acc <= s - CLK_HZ and the square bit toggles.
  - Otherwise: acc <= s.
  - Result: the square wave runs at exactly tone Hz on average.
- Silent channel (tone >= SIL_HZ or tone == 0): acc is held at 0, the square bit is held at 0, and the sample is 0.
- Amplitude from volume:
  - 0 -> 0x0000
  - 1 -> 0x1000
  - 2 -> 0x2000
  - 3 -> 0x4000
  - 4..7 -> 0x7000 (saturated)
- Sample value:
  - square=1 -> +amp
  - square=0 -> -amp (two's complement, e.g. -0x7000 = 0x9000)
  - silent or mute -> 0x0000
- Frame latch: at the cycle where cnt wraps 511->0, frameL and frameR capture the current left and right samples.
  - The captured samples are held for the whole 512-clk frame.
  - Samples changing mid-frame do not affect the word being shifted.
- Serial data: bit index b = 15 - cnt_next[7:4].
  - audio_sdin is registered from frameL[b] when cnt_next[8] = 0, and from frameR[b] when cnt_next[8] = 1.
  - The data therefore changes only on the falling edge of audio_sck.
  - Exactly 16 bits per channel, with no pad bits.
- Latency: a tone change appears in the serial stream at the first frame latch after a half-period elapses.
  - The bound is one frame (512 clk) plus the tone half-period.
- Reset asserted mid-frame: all outputs drop to 0 asynchronously.
  - After release, counting restarts at cnt = 0, and the first frame transmits zeros.
- Simultaneous tone change and accumulator overflow: the phase reset wins, so the square bit is 0.
- Boundary: tone = SIL_HZ - 1 is a valid tone.
  - The square bit toggles on nearly every cycle.
  - No overflow of the 33-bit intermediate is permitted.

Test Plan:
- Reset, then hold rst_n=0 for 10 clk -> all outputs 0. After release, audio_lrck first rises at clk 256 and audio_sck has period 16 clk.
- toneL=1000, toneR=SIL_HZ, volume=3 -> left square toggles every 50000 clk. Left words alternate 0x4000 / 0xC000 across frames. Right words are always 0x0000.
- volume=7 with left square low -> left word on sdin = 0x9000 (1001 0000 0000 0000, MSB first). volume=0 -> 0x0000.
- toneL changed from 1000 to 2000 mid-period -> acc and square clear on the next clk, and the next toggle occurs 25000 clk later. The frame already being shifted is unchanged.
- mute=1 mid-frame -> the current frame finishes unchanged, and every later word is 0x0000 until mute=0.
- Assert rst_n low at cnt=300 during a right word -> sdin, lrck, sck and mclk go 0 immediately. After release, the first full frame transmits all zeros.
